axi_reg_arbiter: RTL and testbench

Shares one AXI register-bank slave (4-bit IDs, 32-bit data, 8 x 32-bit registers) between N_REQ local requesters.
Each requester issues single-word read or write commands on a simple valid/ready port. The block arbitrates round-robin, runs exactly one AXI transaction at a time through AW/W/B or AR/R, and returns a one-cycle response to the winning requester.
It sits between the counter/control logic and the register slave.

---
 rtl/axi_reg_arbiter_pkg.sv | 20 ++
 rtl/axi_reg_arbiter_if.sv | 46 ++++
 rtl/axi_reg_arbiter_rr_arbiter.sv | 33 +++
 rtl/axi_reg_arbiter.sv | 169 ++++++++++++++++
 tb/tb_axi_reg_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_reg_arbiter_pkg.sv
// rtl/axi_reg_arbiter_pkg.sv - shared types and constants for the AXI register arbiter
package axi_reg_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_DATA_W = 32;
  localparam int STRB_W     = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_ERR_RSP
  } arb_state_t;

endpackage

// File: rtl/axi_reg_arbiter_if.sv
// rtl/axi_reg_arbiter_if.sv - single-beat AXI bus between arbiter (master) and register bank (slave)
interface axi_reg_arbiter_if #(
  parameter int ADDR_W = 32
);
  import axi_reg_pkg::*;

  logic [AXI_ID_W-1:0]   awid;
  logic [ADDR_W-1:0]     awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [AXI_ID_W-1:0]   wid;
  logic [AXI_DATA_W-1:0] wdata;
  logic [STRB_W-1:0]     wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [AXI_ID_W-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [AXI_ID_W-1:0]   arid;
  logic [ADDR_W-1:0]     araddr;
  logic                  arvalid;
  logic                  arready;
  logic [AXI_ID_W-1:0]   rid;
  logic [AXI_DATA_W-1:0] rdata;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awvalid, input awready,
    output wid, wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arvalid, input arready,
    input rid, rdata, rvalid, output rready
  );

  modport slave (
    input awid, awaddr, awvalid, output awready,
    input wid, wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arvalid, output arready,
    output rid, rdata, rvalid, input rready
  );

endinterface

// File: rtl/axi_reg_arbiter_rr_arbiter.sv
// rtl/axi_reg_arbiter_rr_arbiter.sv - combinational round-robin pick starting after the last winner
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  input  logic             i_enable,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx
);

  logic w_found;

  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return IDX_W'(v % N_REQ);
  endfunction

  // scan ptr+1, ptr+2, ... wrapping; the last granted index gets lowest priority
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (i_enable && !w_found && i_req[wrap_idx(int'(i_ptr) + k)]) begin
        w_found                           = 1'b1;
        o_grant[wrap_idx(int'(i_ptr) + k)] = 1'b1;
        o_idx                             = wrap_idx(int'(i_ptr) + k);
      end
    end
  end

endmodule

// File: rtl/axi_reg_arbiter.sv
// rtl/axi_reg_arbiter.sv - round-robin sharing of one AXI register slave among local requesters
module axi_reg_arbiter
  import axi_reg_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int REG_COUNT = 8,
  parameter int ADDR_W    = 32
) (
  input  logic                    clk,
  input  logic                    areset,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic [N_REQ-1:0]        req_we_i,
  input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [N_REQ*32-1:0]     req_wdata_i,
  input  logic [N_REQ*4-1:0]      req_wstrb_i,
  output logic [N_REQ-1:0]        rsp_valid_o,
  output logic [31:0]             rsp_rdata_o,
  output logic                    rsp_err_o,
  axi_reg_arbiter_if.master       m_axi
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t          r_state;
  arb_state_t          w_next;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_gnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [3:0]          r_wstrb;
  logic                r_awvalid;
  logic                r_wvalid;
  logic                r_arvalid;
  logic [N_REQ-1:0]    r_rsp_valid;
  logic                r_rsp_err;
  logic [31:0]         r_rsp_rdata;

  logic [N_REQ-1:0]    w_grant;
  logic [IDX_W-1:0]    w_idx;
  logic                w_capture;
  logic [ADDR_W-1:0]   w_cmd_addr;
  logic                w_cmd_we;
  logic                w_cmd_bad;
  logic                w_aw_done;
  logic                w_w_done;
  logic                w_b_fire;
  logic                w_r_fire;
  logic [AXI_ID_W-1:0] w_id;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .i_req    (req_valid_i),
    .i_ptr    (r_ptr),
    .i_enable ((r_state == ST_IDLE) && !areset),
    .o_grant  (w_grant),
    .o_idx    (w_idx)
  );

  assign w_capture  = (r_state == ST_IDLE) && (w_grant != '0);
  assign w_cmd_addr = req_addr_i[int'(w_idx)*ADDR_W +: ADDR_W];
  assign w_cmd_we   = req_we_i[w_idx];
  assign w_cmd_bad  = (w_cmd_addr >= ADDR_W'(REG_COUNT));
  assign w_aw_done  = !r_awvalid || m_axi.awready;
  assign w_w_done   = !r_wvalid || m_axi.wready;
  assign w_b_fire   = (r_state == ST_WR_RESP) && m_axi.bvalid;
  assign w_r_fire   = (r_state == ST_RD_DATA) && m_axi.rvalid;
  assign w_id       = AXI_ID_W'(r_gnt);

  assign m_axi.awid    = w_id;
  assign m_axi.awaddr  = r_addr;
  assign m_axi.awvalid = r_awvalid;
  assign m_axi.wid     = w_id;
  assign m_axi.wdata   = r_wdata;
  assign m_axi.wstrb   = r_wstrb;
  assign m_axi.wlast   = 1'b1;
  assign m_axi.wvalid  = r_wvalid;
  assign m_axi.arid    = w_id;
  assign m_axi.araddr  = r_addr;
  assign m_axi.arvalid = r_arvalid;
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_rdata_o   = r_rsp_rdata;
  assign rsp_err_o     = r_rsp_err;

  // state register
  always_ff @(posedge clk) begin
    if (areset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // next state plus the combinational handshakes (grant, bready, rready)
  always_comb begin
    w_next       = r_state;
    req_ready_o  = '0;
    m_axi.bready = 1'b0;
    m_axi.rready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready_o = w_grant;
        if (w_capture) begin
          if (w_cmd_bad)     w_next = ST_ERR_RSP;
          else if (w_cmd_we) w_next = ST_WR_REQ;
          else               w_next = ST_RD_REQ;
        end
      end
      ST_WR_REQ:  if (w_aw_done && w_w_done) w_next = ST_WR_RESP;
      ST_WR_RESP: begin
        m_axi.bready = 1'b1;
        if (m_axi.bvalid) w_next = ST_IDLE;
      end
      ST_RD_REQ:  if (m_axi.arready) w_next = ST_RD_DATA;
      ST_RD_DATA: begin
        m_axi.rready = 1'b1;
        if (m_axi.rvalid) w_next = ST_IDLE;
      end
      ST_ERR_RSP: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // command capture, independent AW/W valid retirement and the one-cycle response pulse
  always_ff @(posedge clk) begin
    if (areset) begin
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= '0;
      r_rsp_err   <= 1'b0;
      if (w_capture) begin
        r_ptr     <= w_idx;
        r_gnt     <= w_idx;
        r_addr    <= w_cmd_addr;
        r_wdata   <= req_wdata_i[int'(w_idx)*32 +: 32];
        r_wstrb   <= req_wstrb_i[int'(w_idx)*4 +: 4];
        r_awvalid <= w_cmd_we && !w_cmd_bad;
        r_wvalid  <= w_cmd_we && !w_cmd_bad;
        r_arvalid <= !w_cmd_we && !w_cmd_bad;
        if (w_cmd_bad) begin
          r_rsp_valid <= w_grant;
          r_rsp_err   <= 1'b1;
        end
      end
      if (r_awvalid && m_axi.awready) r_awvalid <= 1'b0;
      if (r_wvalid && m_axi.wready)   r_wvalid  <= 1'b0;
      if (r_arvalid && m_axi.arready) r_arvalid <= 1'b0;
      if (w_b_fire) begin
        r_rsp_valid <= N_REQ'(1) << r_gnt;
        r_rsp_err   <= (m_axi.bresp != RESP_OKAY) || (m_axi.bid != w_id);
      end
      if (w_r_fire) begin
        r_rsp_valid <= N_REQ'(1) << r_gnt;
        r_rsp_err   <= (m_axi.rid != w_id);
        r_rsp_rdata <= m_axi.rdata;
      end
    end
  end

endmodule

// File: tb/tb_axi_reg_arbiter.sv
// tb/tb_axi_reg_arbiter.sv - directed and randomized checks of axi_reg_arbiter against a transaction-level model
module tb_axi_reg_arbiter;
  import axi_reg_pkg::*;

  localparam int N  = 2;
  localparam int RC = 8;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            areset = 1'b1;
  logic [N-1:0]    req_valid_i = '0;
  logic [N-1:0]    req_ready_o;
  logic [N-1:0]    req_we_i = '0;
  logic [N*AW-1:0] req_addr_i = '0;
  logic [N*32-1:0] req_wdata_i = '0;
  logic [N*4-1:0]  req_wstrb_i = '0;
  logic [N-1:0]    rsp_valid_o;
  logic [31:0]     rsp_rdata_o;
  logic            rsp_err_o;

  axi_reg_arbiter_if #(.ADDR_W(AW)) axi ();

  axi_reg_arbiter #(.N_REQ(N), .REG_COUNT(RC), .ADDR_W(AW)) dut (
    .clk         (clk),
    .areset      (areset),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_wstrb_i (req_wstrb_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .m_axi       (axi)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // slave environment knobs and observations
  int          aw_dly = 0, w_dly = 0, ar_dly = 0;
  bit          r_hold = 0, inj_bresp = 0, inj_id = 0;
  logic [31:0] s_mem [RC];
  bit          aw_fire, w_fire, ar_fire, b_fire, r_fire;
  bit          aw_have, w_have, ar_have, aw_unstable;
  int          aw_cyc, w_cyc, ar_cyc, last_aw_cyc, last_w_cyc;
  int          n_aw = 0, n_w = 0, n_ar = 0, n_b = 0;
  logic [3:0]  s_awid, s_wid, s_arid, s_wstrb;
  logic [31:0] s_awaddr, s_araddr, s_wdata, aw_prev;

  // reference model
  logic [31:0] m_mem [RC];
  int          m_ptr = 0;
  bit          c_we [N];
  logic [31:0] c_addr [N], c_wd [N];
  logic [3:0]  c_st [N];

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  // register-bank slave: decides readiness at the falling edge, handshakes land on the next rising edge
  initial begin
    axi.awready = 0; axi.wready = 0; axi.arready = 0;
    axi.bvalid = 0; axi.bid = 0; axi.bresp = 0;
    axi.rvalid = 0; axi.rid = 0; axi.rdata = 0;
    forever begin
      @(negedge clk);
      if (areset) begin
        axi.awready = 0; axi.wready = 0; axi.arready = 0; axi.bvalid = 0; axi.rvalid = 0;
        {aw_fire, w_fire, ar_fire, b_fire, r_fire, aw_have, w_have, ar_have} = '0;
        aw_cyc = 0; w_cyc = 0; ar_cyc = 0;
      end else begin
        if (aw_fire) aw_have = 1;
        if (w_fire)  w_have = 1;
        if (ar_fire) ar_have = 1;
        if (b_fire) begin axi.bvalid = 0; n_b++; end
        if (r_fire) axi.rvalid = 0;
        if (aw_have && w_have && !axi.bvalid) begin
          if (s_awaddr < RC)
            for (int b = 0; b < 4; b++)
              if (s_wstrb[b]) s_mem[s_awaddr[2:0]][8*b +: 8] = s_wdata[8*b +: 8];
          axi.bvalid = 1;
          axi.bid    = inj_id ? (s_awid ^ 4'h1) : s_awid;
          axi.bresp  = inj_bresp ? RESP_SLVERR : RESP_OKAY;
          aw_have = 0; w_have = 0;
        end
        if (ar_have && !axi.rvalid && !r_hold) begin
          axi.rvalid = 1;
          axi.rdata  = s_mem[s_araddr[2:0]];
          axi.rid    = inj_id ? (s_arid ^ 4'h1) : s_arid;
          ar_have = 0;
        end
        if (axi.awvalid) begin
          if (aw_cyc > 0 && axi.awaddr !== aw_prev) aw_unstable = 1;
          aw_prev = axi.awaddr; aw_cyc++;
          axi.awready = (aw_cyc > aw_dly); aw_fire = axi.awready;
          if (aw_fire) begin s_awid = axi.awid; s_awaddr = axi.awaddr; last_aw_cyc = aw_cyc; aw_cyc = 0; n_aw++; end
        end else begin axi.awready = 0; aw_fire = 0; aw_cyc = 0; end
        if (axi.wvalid) begin
          w_cyc++;
          axi.wready = (w_cyc > w_dly); w_fire = axi.wready;
          if (w_fire) begin s_wid = axi.wid; s_wdata = axi.wdata; s_wstrb = axi.wstrb; last_w_cyc = w_cyc; w_cyc = 0; n_w++; end
        end else begin axi.wready = 0; w_fire = 0; w_cyc = 0; end
        if (axi.arvalid) begin
          ar_cyc++;
          axi.arready = (ar_cyc > ar_dly); ar_fire = axi.arready;
          if (ar_fire) begin s_arid = axi.arid; s_araddr = axi.araddr; ar_cyc = 0; n_ar++; end
        end else begin axi.arready = 0; ar_fire = 0; ar_cyc = 0; end
        b_fire = axi.bvalid && axi.bready;
        r_fire = axi.rvalid && axi.rready;
      end
    end
  end

  task automatic cmd(input int r, input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
    c_we[r] = we; c_addr[r] = a; c_wd[r] = wd; c_st[r] = st;
  endtask

  task automatic serve_one(input logic [N-1:0] pend, output int g);
    int eg, lat, exp_lat, naw0, nw0, nar0, nb0;
    bit got, bad, exp_err;
    eg = rr_pick(pend, m_ptr);
    got = 0;
    for (int t = 0; t < 40; t++) begin
      if (req_ready_o != '0) begin got = 1; break; end
      @(negedge clk);
    end
    check("grant_seen", got, 1);
    check("grant_onehot", req_ready_o, N'(1) << eg);
    g = eg; m_ptr = eg;
    naw0 = n_aw; nw0 = n_w; nar0 = n_ar; nb0 = n_b;
    @(posedge clk);
    #1 req_valid_i[eg] = 0;
    got = 0; lat = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk); lat++;
      if (rsp_valid_o != '0) begin got = 1; break; end
    end
    check("rsp_seen", got, 1);
    bad = (c_addr[eg] >= RC);
    if (bad) begin
      exp_lat = 1; exp_err = 1;
    end else if (c_we[eg]) begin
      exp_lat = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly);
      exp_err = inj_bresp || inj_id;
      for (int b = 0; b < 4; b++)
        if (c_st[eg][b]) m_mem[c_addr[eg][2:0]][8*b +: 8] = c_wd[eg][8*b +: 8];
    end else begin
      exp_lat = 3 + ar_dly; exp_err = inj_id;
    end
    check("rsp_owner", rsp_valid_o, N'(1) << eg);
    check("rsp_latency", lat, exp_lat);
    check("rsp_err", rsp_err_o, exp_err);
    #2;
    if (bad) begin
      check("no_axi_on_reject", (n_aw - naw0) + (n_w - nw0) + (n_ar - nar0), 0);
    end else if (c_we[eg]) begin
      check("aw_id", s_awid, eg);
      check("w_id", s_wid, eg);
      check("aw_addr", s_awaddr, c_addr[eg]);
      check("w_data", {s_wstrb, s_wdata}, {c_st[eg], c_wd[eg]});
      check("b_count", n_b - nb0, 1);
      check("aw_addr_stable", aw_unstable, 0);
    end else begin
      check("ar_id", s_arid, eg);
      check("ar_addr", s_araddr, c_addr[eg]);
      check("rdata", rsp_rdata_o, m_mem[c_addr[eg][2:0]]);
    end
  endtask

  task automatic run_batch(input logic [N-1:0] mask);
    logic [N-1:0] pend;
    int g;
    @(negedge clk);
    for (int r = 0; r < N; r++) begin
      if (mask[r]) begin
        req_we_i[r] = c_we[r];
        req_addr_i[r*AW +: AW] = c_addr[r];
        req_wdata_i[r*32 +: 32] = c_wd[r];
        req_wstrb_i[r*4 +: 4] = c_st[r];
        req_valid_i[r] = 1;
      end
    end
    #1;
    pend = mask;
    while (pend != '0) begin
      serve_one(pend, g);
      pend[g] = 0;
    end
  endtask

  initial begin
    logic [N-1:0] mask;
    bit seen;
    for (int i = 0; i < RC; i++) begin m_mem[i] = $urandom; s_mem[i] = m_mem[i]; end

    // reset state, with both requesters asking during reset
    areset = 1; req_valid_i = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", req_ready_o, 0);
    check("rst_rsp", {rsp_valid_o, rsp_err_o}, 0);
    check("rst_rdata", rsp_rdata_o, 0);
    check("rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
    check("rst_aw", {axi.awid, axi.awaddr}, 0);
    check("rst_w", {axi.wid, axi.wdata, axi.wstrb}, 0);
    check("rst_ar", {axi.arid, axi.araddr}, 0);
    check("wlast", axi.wlast, 1);
    req_valid_i = '0;
    @(posedge clk);
    #1 areset = 0; m_ptr = 0;

    // both requesters reading address 1 back to back
    cmd(0, 0, 1, 0, 0); cmd(1, 0, 1, 0, 0);
    run_batch(2'b11);
    run_batch(2'b11);

    // single write then read-back
    cmd(0, 1, 3, 32'hDEADBEEF, 4'hF);
    run_batch(2'b01);
    cmd(1, 0, 3, 0, 0);
    run_batch(2'b10);

    // slow AW, fast W
    aw_dly = 2; w_dly = 0;
    cmd(1, 1, 6, 32'h1234_5678, 4'b0101);
    run_batch(2'b10);
    check("aw_hold_cycles", last_aw_cyc, 3);
    check("w_hold_cycles", last_w_cyc, 1);
    aw_dly = 0;

    // out-of-range address, SLVERR, ID mismatch
    cmd(0, 0, 8, 0, 0);
    run_batch(2'b01);
    inj_bresp = 1; cmd(0, 1, 2, 32'hA5A5_0F0F, 4'hF); run_batch(2'b01); inj_bresp = 0;
    inj_id = 1; cmd(1, 0, 2, 0, 0); run_batch(2'b10); inj_id = 0;

    // reset while waiting in RD_DATA
    r_hold = 1;
    cmd(0, 0, 5, 0, 0);
    @(negedge clk);
    req_we_i[0] = 0; req_addr_i[0 +: AW] = 5; req_valid_i[0] = 1;
    @(posedge clk);
    #1 req_valid_i[0] = 0;
    seen = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (axi.rready) begin seen = 1; break; end
    end
    check("rready_seen", seen, 1);
    areset = 1;
    @(posedge clk);
    @(posedge clk);
    #1 areset = 0;
    @(negedge clk);
    check("abort_outputs", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, rsp_valid_o}, 0);
    seen = 0;
    repeat (4) begin @(negedge clk); if (rsp_valid_o != '0) seen = 1; end
    check("abort_no_rsp", seen, 0);
    r_hold = 0; m_ptr = 0;
    cmd(0, 0, 4, 0, 0); cmd(1, 0, 7, 0, 0);
    run_batch(2'b11);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int r = 0; r < N; r++)
        cmd(r, 1'($urandom % 2), $urandom_range(0, 9), $urandom, 4'($urandom_range(0, 15)));
      aw_dly = $urandom_range(0, 2); w_dly = $urandom_range(0, 2); ar_dly = $urandom_range(0, 2);
      inj_bresp = ($urandom % 6 == 0); inj_id = ($urandom % 6 == 0);
      run_batch(mask);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
